// File: rtl/vga_test_pattern_gen_pkg.sv
// Shared constants and helpers for the VGA test-pattern generator: 640x480 timing,
// pattern codes, moving-box direction encoding and the per-axis bounce step.
package vga_test_pattern_gen_pkg;

    localparam int CNT_W           = 10;
    localparam int PAT_W           = 3;
    localparam int VIDEO_WIDTH_C   = 3;
    localparam int TOTAL_COLS_C    = 800;
    localparam int TOTAL_ROWS_C    = 525;
    localparam int ACTIVE_COLS_C   = 640;
    localparam int ACTIVE_ROWS_C   = 480;
    localparam int CHECKER_LOG2_C  = 5;
    localparam int BOX_SIZE_C      = 32;

    localparam logic [PAT_W-1:0] PAT_BLACK   = 3'd0;
    localparam logic [PAT_W-1:0] PAT_RED     = 3'd1;
    localparam logic [PAT_W-1:0] PAT_WHITE   = 3'd2;
    localparam logic [PAT_W-1:0] PAT_CHECKER = 3'd3;
    localparam logic [PAT_W-1:0] PAT_BARS    = 3'd4;
    localparam logic [PAT_W-1:0] PAT_BOX     = 3'd5;

    // bit 0 set = moving left, bit 1 set = moving up
    typedef enum logic [1:0] {
        BOX_RIGHT_DOWN = 2'b00,
        BOX_LEFT_DOWN  = 2'b01,
        BOX_RIGHT_UP   = 2'b10,
        BOX_LEFT_UP    = 2'b11
    } box_dir_e;

    typedef struct packed {
        logic             back;
        logic [CNT_W-1:0] pos;
    } axis_step_t;

    function automatic axis_step_t axis_step(input logic [CNT_W-1:0] pos,
                                             input logic             back,
                                             input logic [CNT_W-1:0] hi);
        axis_step_t r;
        if (!back && (pos == hi)) begin
            r.back = 1'b1;
            r.pos  = pos - 10'd1;
        end else if (back && (pos == 10'd0)) begin
            r.back = 1'b0;
            r.pos  = pos + 10'd1;
        end else if (back) begin
            r.back = 1'b1;
            r.pos  = pos - 10'd1;
        end else begin
            r.back = 1'b0;
            r.pos  = pos + 10'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_test_pattern_gen_if.sv
// Video bundle between the sync pulse generator, the pattern generator and the porch stage.
interface vga_test_pattern_gen_if #(parameter int VIDEO_WIDTH = 3);
    import vga_test_pattern_gen_pkg::*;

    logic                   i_HSync;
    logic                   i_VSync;
    logic [PAT_W-1:0]       i_Pattern;
    logic                   o_HSync;
    logic                   o_VSync;
    logic [VIDEO_WIDTH-1:0] o_Red_Video;
    logic [VIDEO_WIDTH-1:0] o_Grn_Video;
    logic [VIDEO_WIDTH-1:0] o_Blu_Video;
    logic                   o_Frame_Start;

    modport master (
        output i_HSync, i_VSync, i_Pattern,
        input  o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video, o_Frame_Start
    );

    modport slave (
        input  i_HSync, i_VSync, i_Pattern,
        output o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video, o_Frame_Start
    );
endinterface

// File: rtl/vga_test_pattern_gen_count.sv
// Stage 1: rebuilds col/row from raw syncs. A VSync rise re-zeroes the counters and
// locks; syncs are delayed one clock so they line up with the counts.
module vga_test_pattern_gen_count
    import vga_test_pattern_gen_pkg::*;
#(
    parameter int TOTAL_COLS = TOTAL_COLS_C,
    parameter int TOTAL_ROWS = TOTAL_ROWS_C
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_HSync,
    input  logic             i_VSync,
    output logic [CNT_W-1:0] o_Col,
    output logic [CNT_W-1:0] o_Row,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic             o_Locked,
    output logic             o_Rise,
    output logic             o_Col_Clr
);

    localparam logic [CNT_W-1:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = 10'(TOTAL_ROWS - 1);

    logic vsync_prev_r;
    logic rise_s;
    logic col_wrap_s;

    assign rise_s     = i_VSync & ~vsync_prev_r;
    assign col_wrap_s = (o_Col == COL_LAST);
    assign o_Rise     = rise_s;
    assign o_Col_Clr  = rise_s | col_wrap_s;

    // Edge detect, counters, lock flag and sync delay. The previous-VSync flop resets
    // high so a reset released mid-frame waits for a genuine rise before re-locking.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            vsync_prev_r <= 1'b1;
            o_Col        <= 10'd0;
            o_Row        <= 10'd0;
            o_HSync      <= 1'b0;
            o_VSync      <= 1'b0;
            o_Locked     <= 1'b0;
        end else begin
            vsync_prev_r <= i_VSync;
            o_HSync      <= i_HSync;
            o_VSync      <= i_VSync;
            if (rise_s) begin
                o_Col    <= 10'd0;
                o_Row    <= 10'd0;
                o_Locked <= 1'b1;
            end else if (col_wrap_s) begin
                o_Col <= 10'd0;
                o_Row <= (o_Row == ROW_LAST) ? 10'd0 : o_Row + 10'd1;
            end else begin
                o_Col <= o_Col + 10'd1;
            end
        end
    end

endmodule

// File: rtl/vga_test_pattern_gen.sv
// Test-pattern source: stage-1 counts, per-frame pattern latch, bar counter, bouncing
// box and a registered stage-2 colour mux, all aligned two clocks behind the input syncs.
module vga_test_pattern_gen
    import vga_test_pattern_gen_pkg::*;
#(
    parameter int VIDEO_WIDTH  = VIDEO_WIDTH_C,
    parameter int TOTAL_COLS   = TOTAL_COLS_C,
    parameter int TOTAL_ROWS   = TOTAL_ROWS_C,
    parameter int ACTIVE_COLS  = ACTIVE_COLS_C,
    parameter int ACTIVE_ROWS  = ACTIVE_ROWS_C,
    parameter int CHECKER_LOG2 = CHECKER_LOG2_C,
    parameter int BOX_SIZE     = BOX_SIZE_C
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    vga_test_pattern_gen_if.slave vid
);

    localparam logic [CNT_W-1:0]       ACT_COLS = 10'(ACTIVE_COLS);
    localparam logic [CNT_W-1:0]       ACT_ROWS = 10'(ACTIVE_ROWS);
    localparam logic [CNT_W-1:0]       BOX_W    = 10'(BOX_SIZE);
    localparam logic [CNT_W-1:0]       X_HI     = 10'(ACTIVE_COLS - BOX_SIZE);
    localparam logic [CNT_W-1:0]       Y_HI     = 10'(ACTIVE_ROWS - BOX_SIZE);
    localparam logic [CNT_W-1:0]       BAR_LAST = 10'(ACTIVE_COLS / 8 - 1);
    localparam logic [VIDEO_WIDTH-1:0] MAX_C    = {VIDEO_WIDTH{1'b1}};

    logic [CNT_W-1:0]       col_s, row_s;
    logic                   hs1_s, vs1_s, locked_s, rise_s, col_clr_s;
    logic [PAT_W-1:0]       pattern_r;
    logic                   fs1_r;
    logic [CNT_W-1:0]       bar_cnt_r;
    logic [2:0]             bar_idx_r;
    box_dir_e               box_state_r, box_state_n;
    logic [1:0]             box_dir_s;
    logic [CNT_W-1:0]       box_x_r, box_y_r, box_x_n, box_y_n;
    axis_step_t             x_step_s, y_step_s;
    logic                   box_in_s;
    logic [VIDEO_WIDTH-1:0] red_s, grn_s, blu_s;

    vga_test_pattern_gen_count #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_count (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_HSync   (vid.i_HSync),
        .i_VSync   (vid.i_VSync),
        .o_Col     (col_s),
        .o_Row     (row_s),
        .o_HSync   (hs1_s),
        .o_VSync   (vs1_s),
        .o_Locked  (locked_s),
        .o_Rise    (rise_s),
        .o_Col_Clr (col_clr_s)
    );

    // Pattern latch, frame-start flag and bar sub-counter kept in step with stage-1 col
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            pattern_r <= PAT_BLACK;
            fs1_r     <= 1'b0;
            bar_cnt_r <= 10'd0;
            bar_idx_r <= 3'd0;
        end else begin
            fs1_r <= rise_s;
            if (rise_s) begin
                pattern_r <= vid.i_Pattern;
            end
            if (col_clr_s) begin
                bar_cnt_r <= 10'd0;
                bar_idx_r <= 3'd0;
            end else if (bar_cnt_r == BAR_LAST) begin
                bar_cnt_r <= 10'd0;
                bar_idx_r <= bar_idx_r + 3'd1;
            end else begin
                bar_cnt_r <= bar_cnt_r + 10'd1;
            end
        end
    end

    // Box FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            box_state_r <= BOX_RIGHT_DOWN;
            box_x_r     <= 10'd0;
            box_y_r     <= 10'd0;
        end else begin
            box_state_r <= box_state_n;
            box_x_r     <= box_x_n;
            box_y_r     <= box_y_n;
        end
    end

    // Box FSM next state: one pixel per axis per frame start, bouncing at the edges
    always_comb begin
        box_dir_s = box_state_r;
        x_step_s  = axis_step(box_x_r, box_dir_s[0], X_HI);
        y_step_s  = axis_step(box_y_r, box_dir_s[1], Y_HI);
        if (rise_s) begin
            box_state_n = box_dir_e'({y_step_s.back, x_step_s.back});
            box_x_n     = x_step_s.pos;
            box_y_n     = y_step_s.pos;
        end else begin
            box_state_n = box_state_r;
            box_x_n     = box_x_r;
            box_y_n     = box_y_r;
        end
    end

    // Box FSM output: current stage-1 pixel lies inside the box
    always_comb begin
        if ((col_s >= box_x_r) && (col_s < box_x_r + BOX_W) &&
            (row_s >= box_y_r) && (row_s < box_y_r + BOX_W)) begin
            box_in_s = 1'b1;
        end else begin
            box_in_s = 1'b0;
        end
    end

    // Colour selection for the stage-1 pixel; blanking and unlocked both give black
    always_comb begin
        red_s = '0;
        grn_s = '0;
        blu_s = '0;
        if (locked_s && (col_s < ACT_COLS) && (row_s < ACT_ROWS)) begin
            case (pattern_r)
                PAT_BLACK: begin
                    red_s = '0;
                end
                PAT_RED: begin
                    red_s = MAX_C;
                end
                PAT_WHITE: begin
                    red_s = MAX_C;
                    grn_s = MAX_C;
                    blu_s = MAX_C;
                end
                PAT_CHECKER: begin
                    if (col_s[CHECKER_LOG2] ^ row_s[CHECKER_LOG2]) begin
                        red_s = MAX_C;
                        grn_s = MAX_C;
                        blu_s = MAX_C;
                    end else begin
                        red_s = '0;
                    end
                end
                PAT_BARS: begin
                    red_s = bar_idx_r[2] ? MAX_C : '0;
                    grn_s = bar_idx_r[1] ? MAX_C : '0;
                    blu_s = bar_idx_r[0] ? MAX_C : '0;
                end
                PAT_BOX: begin
                    if (box_in_s) begin
                        red_s = MAX_C;
                        grn_s = MAX_C;
                        blu_s = MAX_C;
                    end else begin
                        red_s = '0;
                    end
                end
                default: begin
                    red_s = '0;
                end
            endcase
        end else begin
            red_s = '0;
        end
    end

    // Stage 2: registered outputs, two clocks behind the raw syncs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            vid.o_HSync       <= 1'b0;
            vid.o_VSync       <= 1'b0;
            vid.o_Red_Video   <= '0;
            vid.o_Grn_Video   <= '0;
            vid.o_Blu_Video   <= '0;
            vid.o_Frame_Start <= 1'b0;
        end else begin
            vid.o_HSync       <= hs1_s;
            vid.o_VSync       <= vs1_s;
            vid.o_Red_Video   <= red_s;
            vid.o_Grn_Video   <= grn_s;
            vid.o_Blu_Video   <= blu_s;
            vid.o_Frame_Start <= fs1_r;
        end
    end

endmodule

// File: tb/tb_vga_test_pattern_gen.sv
// Directed bench for vga_test_pattern_gen with hand-computed pixel expectations.
// VSync rises are generated on demand so frames can be far shorter than 525 lines.
module tb_vga_test_pattern_gen;
    import vga_test_pattern_gen_pkg::*;

    localparam logic [8:0] BLACK = 9'h000;
    localparam logic [8:0] WHITE = 9'h1FF;
    localparam logic [8:0] RED   = 9'h1C0;
    localparam logic [8:0] BLUE  = 9'h007;

    logic i_Clk   = 1'b0;
    logic i_Rst_L = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic [8:0] rgb_w;

    vga_test_pattern_gen_if #(.VIDEO_WIDTH(3)) vid ();

    vga_test_pattern_gen u_dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .vid     (vid)
    );

    always #20 i_Clk = ~i_Clk;

    assign rgb_w = {vid.o_Red_Video, vid.o_Grn_Video, vid.o_Blu_Video};

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [8:0] exp);
        check(tag, {7'd0, rgb_w}, {7'd0, exp});
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {15'd0, obs}, {15'd0, exp});
    endtask

    // Leaves the bench sampling pixel (0,0) of the new frame
    task automatic vsync_rise(input string tag, input logic chk);
        vid.i_VSync = 1'b0;
        tick(1);
        vid.i_VSync = 1'b1;
        tick(1);
        if (chk) check_bit({tag, "_vs_d1"}, vid.o_VSync, 1'b0);
        tick(1);
        if (chk) begin
            check_bit({tag, "_vs_d2"}, vid.o_VSync, 1'b1);
            check_bit({tag, "_fs"}, vid.o_Frame_Start, 1'b1);
        end
    endtask

    initial begin
        vid.i_HSync   = 1'b0;
        vid.i_VSync   = 1'b0;
        vid.i_Pattern = 3'd2;
        i_Rst_L       = 1'b0;
        tick(3);

        // 1: reset state, unlocked pass-through, first lock with white
        check_rgb("rst_rgb", BLACK);
        check_bit("rst_hs", vid.o_HSync, 1'b0);
        check_bit("rst_vs", vid.o_VSync, 1'b0);
        check_bit("rst_fs", vid.o_Frame_Start, 1'b0);
        i_Rst_L     = 1'b1;
        vid.i_HSync = 1'b1;
        tick(1);
        check_bit("t1_hs_d1", vid.o_HSync, 1'b0);
        tick(1);
        check_bit("t1_hs_d2", vid.o_HSync, 1'b1);
        check_rgb("t1_unlocked_rgb", BLACK);
        tick(20);
        check_rgb("t1_unlocked_rgb2", BLACK);
        check_bit("t1_unlocked_fs", vid.o_Frame_Start, 1'b0);
        vid.i_HSync = 1'b0;
        tick(1);
        check_bit("t1_hs_fall_d1", vid.o_HSync, 1'b1);
        tick(1);
        check_bit("t1_hs_fall_d2", vid.o_HSync, 1'b0);
        vid.i_HSync = 1'b1;
        vsync_rise("t1", 1'b1);
        check_rgb("t1_px0_white", WHITE);
        tick(1);
        check_bit("t1_fs_pulse_end", vid.o_Frame_Start, 1'b0);
        tick(638);
        check_rgb("t1_col639_white", WHITE);
        tick(1);
        check_rgb("t1_col640_blank", BLACK);

        // 2: colour bars
        vid.i_Pattern = 3'd4;
        vsync_rise("t2", 1'b1);
        check_rgb("t2_col0", BLACK);
        tick(80);
        check_rgb("t2_col80", BLUE);
        tick(559);
        check_rgb("t2_col639", WHITE);
        tick(1);
        check_rgb("t2_col640", BLACK);

        // 3: checkerboard
        vid.i_Pattern = 3'd3;
        vsync_rise("t3", 1'b1);
        tick(31);
        check_rgb("t3_31_0", BLACK);
        tick(1);
        check_rgb("t3_32_0", WHITE);
        tick(32 * 800 - 32);
        check_rgb("t3_0_32", WHITE);
        tick(32);
        check_rgb("t3_32_32", BLACK);

        // 4: moving box from a fresh reset; frame k shows x=y=k until the bounces
        vid.i_Pattern = 3'd5;
        i_Rst_L = 1'b0;
        tick(1);
        i_Rst_L = 1'b1;
        tick(1);
        vsync_rise("t4_f1", 1'b1);
        check_rgb("t4_f1_0_0", BLACK);
        tick(800);
        check_rgb("t4_f1_0_1", BLACK);
        tick(1);
        check_rgb("t4_f1_1_1", WHITE);
        tick(31);
        check_rgb("t4_f1_32_1", WHITE);
        tick(1);
        check_rgb("t4_f1_33_1", BLACK);
        for (int f = 2; f <= 608; f++) vsync_rise("t4_fast", 1'b0);
        check("t4_x_f608", {6'd0, u_dut.box_x_r}, 16'd608);
        vsync_rise("t4_f609", 1'b0);
        check("t4_x_f609", {6'd0, u_dut.box_x_r}, 16'd607);
        check("t4_y_f609", {6'd0, u_dut.box_y_r}, 16'd287);
        check_bit("t4_dir_left", u_dut.box_dir_s[0], 1'b1);
        for (int f = 610; f <= 899; f++) vsync_rise("t4_fast", 1'b0);
        vsync_rise("t4_f900", 1'b1);
        check_rgb("t4_f900_0_0", BLACK);
        tick(3 * 800 + 316);
        check_rgb("t4_f900_316_3", BLACK);
        tick(799);
        check_rgb("t4_f900_315_4", BLACK);
        tick(1);
        check_rgb("t4_f900_316_4", WHITE);
        tick(31);
        check_rgb("t4_f900_347_4", WHITE);
        tick(1);
        check_rgb("t4_f900_348_4", BLACK);

        // 5: pattern change mid-frame takes effect at the next frame start
        vid.i_Pattern = 3'd2;
        vsync_rise("t5", 1'b1);
        tick(10 * 800 + 5);
        check_rgb("t5_5_10_white", WHITE);
        vid.i_Pattern = 3'd1;
        tick(800);
        check_rgb("t5_5_11_still_white", WHITE);
        vsync_rise("t5n", 1'b1);
        check_rgb("t5n_0_0_red", RED);
        tick(5);
        check_rgb("t5n_5_0_red", RED);

        // 6: reset mid-frame with VSync held high, then re-lock on a real rise
        vsync_rise("t6", 1'b1);
        check_rgb("t6_0_0_red", RED);
        tick(20 * 800);
        check_rgb("t6_0_20_red", RED);
        check_bit("t6_hs_pre", vid.o_HSync, 1'b1);
        i_Rst_L = 1'b0;
        #1;
        check_rgb("t6_rst_rgb", BLACK);
        check_bit("t6_rst_hs", vid.o_HSync, 1'b0);
        check_bit("t6_rst_vs", vid.o_VSync, 1'b0);
        tick(2);
        i_Rst_L = 1'b1;
        tick(1);
        check_bit("t6_hs_d1", vid.o_HSync, 1'b0);
        check_bit("t6_vs_d1", vid.o_VSync, 1'b0);
        tick(1);
        check_bit("t6_hs_d2", vid.o_HSync, 1'b1);
        check_bit("t6_vs_d2", vid.o_VSync, 1'b1);
        check_rgb("t6_unlocked_rgb", BLACK);
        tick(50);
        check_rgb("t6_unlocked_rgb2", BLACK);
        check_bit("t6_unlocked_fs", vid.o_Frame_Start, 1'b0);
        vsync_rise("t6r", 1'b1);
        check_rgb("t6r_0_0_red", RED);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
